// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - Flappy Bird round sequencer, input conditioning and BCD scoring
//
// Purpose: owns the IDLE/PLAY/DYING/OVER round state machine, debounces the
// flap button, derives the physics step from vsync and keeps current/best
// BCD scores for the 7-segment display.
//
// Ports:
//   clk          in   system clock
//   clr          in   asynchronous active-low reset
//   flap         in   raw pushbutton (async, active-high)
//   vsync        in   VGA vertical sync (async, active-low)
//   collide      in   bird overlaps pipe or ground (level)
//   pipe_passed  in   one-cycle pulse per pipe cleared
//   state        out  00 IDLE, 01 PLAY, 10 DYING, 11 OVER
//   round_start  out  one-cycle pulse, datapath reinitialises
//   step_en      out  one-cycle physics step pulse
//   flap_out     out  one-cycle flap impulse
//   score_bcd    out  4-digit BCD current score
//   best_bcd     out  4-digit BCD best score
module game_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int TICK_DIV        = 1,
   parameter int DEATH_FRAMES    = 60
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        flap,
   input  logic        vsync,
   input  logic        collide,
   input  logic        pipe_passed,
   output logic [1:0]  state,
   output logic        round_start,
   output logic        step_en,
   output logic        flap_out,
   output logic [15:0] score_bcd,
   output logic [15:0] best_bcd
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PLAY  = 2'b01,
      DYING = 2'b10,
      OVER  = 2'b11
   } state_t;

   state_t cur, nxt;

   logic          flap_s1, flap_s2, deb, deb_d;
   logic [DW-1:0] deb_cnt;
   logic          flap_ev;

   logic          vs1, vs2, vs3;
   logic          frame_ev;
   logic [3:0]    div_cnt;
   logic          step_ev;
   logic          div_clr;

   logic [7:0]    death_cnt, death_nxt;
   logic [15:0]   score_nxt, best_nxt;
   logic          rs_nxt, fo_nxt;

   // Saturating 4-digit BCD increment with per-digit carry.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      if (v != 16'h9999) begin
         for (int i = 0; i < 4; i++) begin
            if (c) begin
               if (r[i*4 +: 4] == 4'd9) begin
                  r[i*4 +: 4] = 4'd0;
               end else begin
                  r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                  c = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   // Flap: 2-flop sync, then the debounced value follows the synced value
   // only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         flap_s1 <= 1'b0;
         flap_s2 <= 1'b0;
         deb     <= 1'b0;
         deb_d   <= 1'b0;
         deb_cnt <= '0;
      end else begin
         flap_s1 <= flap;
         flap_s2 <= flap_s1;
         deb_d   <= deb;
         if (flap_s2 == deb) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb     <= flap_s2;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + DW'(1);
         end
      end
   end

   assign flap_ev = deb & ~deb_d;

   // Vsync: 2-flop sync plus one history flop for falling-edge detect.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         vs1 <= 1'b0;
         vs2 <= 1'b0;
         vs3 <= 1'b0;
      end else begin
         vs1 <= vsync;
         vs2 <= vs1;
         vs3 <= vs2;
      end
   end

   assign frame_ev = vs3 & ~vs2;
   assign step_ev  = frame_ev && (div_cnt == 4'(TICK_DIV - 1));

   // Frame divider; a round start re-phases it so every round's first step
   // lands TICK_DIV frames in.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         div_cnt <= 4'd0;
         step_en <= 1'b0;
      end else begin
         if (div_clr) begin
            div_cnt <= 4'd0;
         end else if (frame_ev) begin
            div_cnt <= step_ev ? 4'd0 : div_cnt + 4'd1;
         end
         step_en <= step_ev && (cur == PLAY || cur == DYING);
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cur         <= IDLE;
         death_cnt   <= 8'd0;
         score_bcd   <= 16'h0000;
         best_bcd    <= 16'h0000;
         round_start <= 1'b0;
         flap_out    <= 1'b0;
      end else begin
         cur         <= nxt;
         death_cnt   <= death_nxt;
         score_bcd   <= score_nxt;
         best_bcd    <= best_nxt;
         round_start <= rs_nxt;
         flap_out    <= fo_nxt;
      end
   end

   always_comb begin
      nxt       = cur;
      death_nxt = death_cnt;
      score_nxt = score_bcd;
      best_nxt  = best_bcd;
      rs_nxt    = 1'b0;
      fo_nxt    = 1'b0;
      div_clr   = 1'b0;
      case (cur)
         IDLE: begin
            // The starting press is consumed here and never becomes a flap.
            if (flap_ev) begin
               nxt       = PLAY;
               rs_nxt    = 1'b1;
               score_nxt = 16'h0000;
               div_clr   = 1'b1;
            end
         end
         PLAY: begin
            if (pipe_passed) begin
               score_nxt = bcd_inc(score_bcd);
            end
            if (collide) begin
               nxt       = DYING;
               death_nxt = 8'(DEATH_FRAMES);
            end else if (flap_ev) begin
               fo_nxt = 1'b1;
            end
         end
         DYING: begin
            if (frame_ev) begin
               death_nxt = (death_cnt == 8'd0) ? 8'd0 : death_cnt - 8'd1;
               if (death_cnt <= 8'd1) begin
                  nxt = OVER;
                  // Best is settled as OVER is entered; score is frozen in DYING.
                  if (score_bcd > best_bcd) begin
                     best_nxt = score_bcd;
                  end
               end
            end
         end
         OVER: begin
            if (flap_ev) begin
               nxt = IDLE;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   assign state = cur;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed self-checking bench for game_ctrl
module tb_game_ctrl;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        flap = 1'b0;
   logic        vsync = 1'b1;
   logic        collide = 1'b0;
   logic        pipe_passed = 1'b0;
   logic [1:0]  state;
   logic        round_start, step_en, flap_out;
   logic [15:0] score_bcd, best_bcd;

   int vectors = 0;
   int miscompares = 0;
   int n_rs = 0, n_step = 0, n_fo = 0, n_both = 0;
   int base_rs, base_step, base_fo;

   game_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .TICK_DIV(2),
      .DEATH_FRAMES(3)
   ) dut (
      .clk(clk),
      .clr(clr),
      .flap(flap),
      .vsync(vsync),
      .collide(collide),
      .pipe_passed(pipe_passed),
      .state(state),
      .round_start(round_start),
      .step_en(step_en),
      .flap_out(flap_out),
      .score_bcd(score_bcd),
      .best_bcd(best_bcd)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (round_start) n_rs++;
      if (step_en) n_step++;
      if (flap_out) n_fo++;
      if (round_start && flap_out) n_both++;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic press();
      flap = 1'b1;
      tick(10);
      flap = 1'b0;
      tick(10);
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         vsync = 1'b0;
         tick(3);
         vsync = 1'b1;
         tick(5);
      end
   endtask

   task automatic pipe_pulses(input int n);
      repeat (n) begin
         pipe_passed = 1'b1;
         tick();
         pipe_passed = 1'b0;
         tick();
      end
   endtask

   task automatic pipe_burst(input int n);
      pipe_passed = 1'b1;
      tick(n);
      pipe_passed = 1'b0;
      tick();
   endtask

   task automatic snap();
      base_rs   = n_rs;
      base_step = n_step;
      base_fo   = n_fo;
   endtask

   initial begin
      // Reset state
      tick(3);
      check("rst_state", 16'(state), 16'h0);
      check("rst_score", score_bcd, 16'h0000);
      check("rst_best", best_bcd, 16'h0000);
      check("rst_pulses", {13'd0, round_start, step_en, flap_out}, 16'h0);
      clr = 1'b1;
      tick(2);

      // Bouncing button: no flap_ev, no round start
      snap();
      for (int i = 0; i < 10; i++) begin
         flap = (i % 2 == 0);
         tick(2);
      end
      check("bounce_rs", 16'(n_rs - base_rs), 16'd0);
      check("bounce_state", 16'(state), 16'h0);

      // Stable high: round_start exactly 2+4+1 cycles after the press
      flap = 1'b1;
      tick(6);
      check("rs_early", 16'(round_start), 16'h0);
      tick();
      check("rs_pulse", 16'(round_start), 16'h1);
      tick();
      check("rs_end", 16'(round_start), 16'h0);
      tick(7);
      flap = 1'b0;
      tick(10);
      check("start_rs_cnt", 16'(n_rs - base_rs), 16'd1);
      check("start_state", 16'(state), 16'h1);
      check("start_no_flap", 16'(n_fo - base_fo), 16'd0);

      // Steps in PLAY
      snap();
      frames(6);
      check("play_steps", 16'(n_step - base_step), 16'd3);

      // Flap in PLAY
      snap();
      press();
      check("play_flap", 16'(n_fo - base_fo), 16'd1);
      check("play_flap_rs", 16'(n_rs - base_rs), 16'd0);

      // Scoring
      pipe_pulses(11);
      check("score_11", score_bcd, 16'h0011);
      pipe_pulses(1);
      check("score_12", score_bcd, 16'h0012);

      // Reset mid-round
      clr = 1'b0;
      #1;
      check("midrst_state", 16'(state), 16'h0);
      check("midrst_score", score_bcd, 16'h0000);
      check("midrst_best", best_bcd, 16'h0000);
      snap();
      flap = 1'b1;
      frames(3);
      flap = 1'b0;
      tick(10);
      check("midrst_pulses", 16'((n_rs - base_rs) + (n_step - base_step) + (n_fo - base_fo)), 16'd0);
      clr = 1'b1;
      tick(2);

      // Round 2: death with simultaneous collide, pipe and flap at score 4
      press();
      check("r2_state", 16'(state), 16'h1);
      pipe_pulses(4);
      check("r2_score4", score_bcd, 16'h0004);
      snap();
      flap = 1'b1;
      tick(6);
      collide = 1'b1;
      pipe_passed = 1'b1;
      tick();
      collide = 1'b0;
      pipe_passed = 1'b0;
      tick(4);
      flap = 1'b0;
      tick(10);
      check("death_score", score_bcd, 16'h0005);
      check("death_state", 16'(state), 16'h2);
      check("death_no_flap", 16'(n_fo - base_fo), 16'd0);
      snap();
      frames(2);
      check("dying_state", 16'(state), 16'h2);
      frames(1);
      check("over_state", 16'(state), 16'h3);
      check("over_best", best_bcd, 16'h0005);
      check("dying_steps", 16'(n_step - base_step), 16'd1);
      snap();
      frames(4);
      check("over_steps", 16'(n_step - base_step), 16'd0);

      // Restart
      press();
      check("restart_idle", 16'(state), 16'h0);
      check("restart_hold", score_bcd, 16'h0005);
      snap();
      frames(2);
      check("idle_steps", 16'(n_step - base_step), 16'd0);
      press();
      check("restart_rs", 16'(n_rs - base_rs), 16'd1);
      check("restart_play", 16'(state), 16'h1);
      check("restart_score", score_bcd, 16'h0000);

      // Round 3: lower score keeps best; DYING ignores pipes and flaps
      pipe_pulses(2);
      collide = 1'b1;
      tick();
      collide = 1'b0;
      tick();
      check("r3_dying", 16'(state), 16'h2);
      pipe_pulses(1);
      check("r3_pipe_ign", score_bcd, 16'h0002);
      snap();
      press();
      check("r3_flap_ign", 16'(n_fo - base_fo), 16'd0);
      frames(3);
      check("r3_over", 16'(state), 16'h3);
      check("r3_best", best_bcd, 16'h0005);

      // Round 4: BCD carry and saturation
      press();
      press();
      check("r4_play", 16'(state), 16'h1);
      pipe_burst(999);
      check("score_0999", score_bcd, 16'h0999);
      pipe_pulses(1);
      check("score_1000", score_bcd, 16'h1000);
      pipe_burst(8999);
      check("score_9999", score_bcd, 16'h9999);
      pipe_pulses(1);
      check("score_sat", score_bcd, 16'h9999);

      check("rs_fo_overlap", 16'(n_both), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Game sequencer for the Flappy Bird datapath. Owns the round state machine (IDLE/PLAY/DYING/OVER).
- Debounces the flap pushbutton and derives the per-frame physics step enable from the VGA vsync.
- Keeps the BCD score and best score for the 7-segment display controller.
- Sits in the top level between the pushbutton, the VGA controller's vsync, the game datapath (step, flap, round start in; collision and pipe-passed out) and segdisplay.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable clk cycles required before the debounced flap changes (10 ms at 100 MHz).
- TICK_DIV, 1: frames per physics step, range 1..15.
- DEATH_FRAMES, 60: frames spent in DYING before OVER, range 1..255.

Ports:
- clk, in, 1: system clock (100 MHz).
- clr, in, 1: reset, asynchronous, active-low.
- flap, in, 1: raw pushbutton, asynchronous, active-high.
- vsync, in, 1: VGA vertical sync, active-low, asynchronous to clk.
- collide, in, 1: level from datapath, bird overlaps a pipe or ground.
- pipe_passed, in, 1: one-cycle pulse from datapath per pipe cleared.
- state, out, 2: 00 IDLE, 01 PLAY, 10 DYING, 11 OVER.
- round_start, out, 1: one-cycle pulse; datapath reinitialises bird and pipes.
- step_en, out, 1: one-cycle physics step pulse.
- flap_out, out, 1: one-cycle flap impulse to datapath.
- score_bcd, out, 16: 4-digit BCD current score.
- best_bcd, out, 16: 4-digit BCD best score.

Behaviour:
- Reset (clr=0, async): state=IDLE; round_start, step_en, flap_out = 0; score_bcd = best_bcd = 0. All synchronizers, counters and the debounced value clear to 0.
- Flap conditioning:
  - 2-flop synchronizer.
  - Counter runs while the synced value differs from the debounced value and clears when they match.
  - At DEBOUNCE_CYCLES the debounced value takes the synced value.
  - flap_ev is a one-cycle pulse on the debounced rising edge. A held button yields exactly one flap_ev.
- Frame conditioning:
  - vsync goes through a 2-flop synchronizer; frame_ev fires on the synced falling edge, one per frame.
  - Frame divider counts frame_ev modulo TICK_DIV; step_ev fires when the count wraps to 0.
- step_en = step_ev registered, gated by state ∈ {PLAY, DYING}. Latency is 1 cycle after frame_ev.
- IDLE:
  - step_en = 0.
  - On flap_ev: go to PLAY, pulse round_start for 1 cycle, clear score_bcd and the frame divider in the same cycle.
  - That flap_ev is not forwarded to flap_out.
- PLAY:
  - flap_ev → flap_out = 1 on the next cycle.
  - pipe_passed → score_bcd += 1 in BCD with per-digit carry. Saturates at 9999, no wrap.
  - collide=1 → DYING; load the death counter with DEATH_FRAMES.
- DYING:
  - flap ignored; step_en keeps running so the bird falls.
  - Death counter decrements on each frame_ev. On reaching 0 → OVER.
  - pipe_passed ignored.
- OVER:
  - step_en = 0.
  - On entry cycle: if score_bcd > best_bcd (unsigned compare of BCD words, valid because BCD order is monotonic), best_bcd ← score_bcd.
  - flap_ev → IDLE. score_bcd is held until the next round_start.
- Simultaneous events in PLAY:
  - collide with pipe_passed: score increments AND go to DYING.
  - collide with flap_ev: go to DYING, flap_out suppressed.
  - frame_ev in the same cycle as the PLAY→DYING transition still produces step_en.
- Only one state transition per cycle. round_start and flap_out never assert in the same cycle.
- best_bcd survives rounds and clears only on reset. Reset mid-round returns everything to reset values immediately.

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIV=2, DEATH_FRAMES=3):
- Reset sanity: assert clr=0 mid-PLAY with score 0x0012 → state=00, score_bcd=0, best_bcd=0, no pulses until clr=1.
- Debounce: flap bounces 1/0 every 2 cycles for 20 cycles, then holds 1 for 10 cycles.
  - No flap_ev during bouncing.
  - Exactly one round_start pulse, about 2+4+1 cycles after the stable high; state=01.
  - The start press gives no flap_out.
- Step enable: in PLAY, 6 vsync falling edges → exactly 3 step_en pulses, each 1 cycle. In IDLE/OVER, vsync edges → 0 pulses.
- Scoring: 11 pipe_passed pulses → score_bcd=0x0011.
  - Preload 0x0999, then 1 pulse → 0x1000.
  - At 0x9999, a further pulse stays at 0x9999.
- Death sequence: collide with pipe_passed and flap press in the same cycle at score 0x0004.
  - score=0x0005, state=10, no flap_out.
  - After 3 frames → state=11, best_bcd=0x0005.
  - Next round scoring 0x0002 ends with best_bcd still 0x0005.
- Restart: in OVER, one press → state=00, score_bcd still shown. Second press → round_start, score_bcd=0, state=01.
